// File: rtl/text_overlay_pkg.sv
// Shared constants for the animated text overlay: mode encodings and coordinate width.
package text_overlay_pkg;

    localparam int COORD_W = 10;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'd0,
        MODE_SCROLL = 2'd1,
        MODE_BLINK  = 2'd2,
        MODE_REVEAL = 2'd3
    } mode_t;

endpackage

// File: rtl/overlay_frame_ticker.sv
// Frame divider: counts enabled frame_start pulses and flags every STEP_FRAMES-th one.
// step is combinational so the animation state advances on the same clock edge.
module overlay_frame_ticker #(
    parameter int STEP_FRAMES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic frame_start,
    input  logic enable,
    input  logic clear,
    output logic step
);

    localparam int DIV_W = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_FRAMES - 1);

    logic [DIV_W-1:0] frame_div;
    logic             advance;

    assign advance = frame_start & enable;

    // Step fires on the last frame of a period unless a mode change is restarting the period.
    always_comb begin
        step = 1'b0;
        if (advance && !clear && (frame_div == DIV_LAST)) begin
            step = 1'b1;
        end else begin
            step = 1'b0;
        end
    end

    // Frame divider: wraps at the period end, restarts on clear, holds while disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_div <= '0;
        end else if (advance) begin
            if (clear || (frame_div == DIV_LAST)) begin
                frame_div <= '0;
            end else begin
                frame_div <= frame_div + DIV_W'(1);
            end
        end else begin
            frame_div <= frame_div;
        end
    end

endmodule

// File: rtl/text_overlay_anim.sv
// Animated 1-bpp text overlay: maps the pixel position to a bitmap cell, applies the
// current animation gate (scroll offset, blink phase or reveal width) and registers the result.
module text_overlay_anim
    import text_overlay_pkg::*;
#(
    parameter int                          TEXT_W      = 46,
    parameter int                          TEXT_H      = 9,
    parameter logic [TEXT_W*TEXT_H-1:0]    BITMAP      = '0,
    parameter int                          SCALE_LOG2  = 3,
    parameter int                          ORIGIN_X    = 18,
    parameter int                          ORIGIN_Y    = 12,
    parameter int                          STEP_FRAMES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic               frame_start,
    input  logic               enable,
    input  logic [1:0]         mode,
    output logic               overlay_active,
    output logic               reveal_done
);

    localparam int CNT_W = 8;
    localparam int IDX_W = 14;
    localparam int BMP_W = TEXT_W * TEXT_H;

    localparam logic [COORD_W-1:0] ORG_X    = COORD_W'(ORIGIN_X);
    localparam logic [COORD_W-1:0] ORG_Y    = COORD_W'(ORIGIN_Y);
    localparam logic [COORD_W-1:0] TW_COORD = COORD_W'(TEXT_W);
    localparam logic [COORD_W-1:0] TH_COORD = COORD_W'(TEXT_H);
    localparam logic [COORD_W:0]   TW_SUM   = (COORD_W+1)'(TEXT_W);
    localparam logic [CNT_W-1:0]   TW_CNT   = CNT_W'(TEXT_W);
    localparam logic [CNT_W-1:0]   TW_LAST  = CNT_W'(TEXT_W - 1);

    mode_t              mode_q;
    logic [CNT_W-1:0]   scroll_pos;
    logic               blink_on;
    logic [CNT_W-1:0]   reveal_cnt;

    logic               mode_change;
    logic               step;
    logic [COORD_W-1:0] col;
    logic [COORD_W-1:0] row;
    logic               in_range;
    logic [COORD_W:0]   scroll_sum;
    logic [COORD_W-1:0] scol;
    logic [IDX_W-1:0]   bit_idx;
    logic [BMP_W-1:0]   bitmap_shift;
    logic               gate;
    logic               pixel_next;

    // A new mode only takes effect at a frame boundary, and only when it actually differs.
    assign mode_change = frame_start & enable & (mode != mode_q);

    overlay_frame_ticker #(
        .STEP_FRAMES (STEP_FRAMES)
    ) u_ticker (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .enable      (enable),
        .clear       (mode_change),
        .step        (step)
    );

    // Cell coordinates relative to the origin; underflow wraps high and falls out of range.
    assign col        = (x >> SCALE_LOG2) - ORG_X;
    assign row        = (y >> SCALE_LOG2) - ORG_Y;
    assign in_range   = (col < TW_COORD) && (row < TH_COORD);
    assign scroll_sum = (COORD_W+1)'(col) + (COORD_W+1)'(scroll_pos);

    // Source column: scrolling wraps with one compare-subtract since both terms are below TEXT_W.
    always_comb begin
        scol = col;
        if (mode_q == MODE_SCROLL) begin
            if (scroll_sum >= TW_SUM) begin
                scol = COORD_W'(scroll_sum - TW_SUM);
            end else begin
                scol = COORD_W'(scroll_sum);
            end
        end else begin
            scol = col;
        end
    end

    // Bit lookup by shifting so an out-of-range index reads zero instead of X.
    assign bit_idx      = IDX_W'(row) * IDX_W'(TEXT_W) + IDX_W'(scol);
    assign bitmap_shift = BITMAP >> bit_idx;

    // Animation gate for the current mode.
    always_comb begin
        gate = 1'b1;
        case (mode_q)
            MODE_STATIC: gate = 1'b1;
            MODE_SCROLL: gate = 1'b1;
            MODE_BLINK:  gate = blink_on;
            MODE_REVEAL: gate = (col < COORD_W'(reveal_cnt));
            default:     gate = 1'b1;
        endcase
    end

    assign pixel_next = bitmap_shift[0] & enable & in_range & gate;

    // Registered pixel flag, recomputed every cycle so it never holds a stale value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overlay_active <= 1'b0;
        end else begin
            overlay_active <= pixel_next;
        end
    end

    // Mode latch and per-step animation state; a mode change restarts the animation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q      <= MODE_STATIC;
            scroll_pos  <= '0;
            blink_on    <= 1'b1;
            reveal_cnt  <= '0;
            reveal_done <= 1'b0;
        end else if (mode_change) begin
            mode_q      <= mode_t'(mode);
            scroll_pos  <= '0;
            blink_on    <= 1'b1;
            reveal_cnt  <= '0;
            reveal_done <= 1'b0;
        end else if (step) begin
            case (mode_q)
                MODE_SCROLL: begin
                    if (scroll_pos >= TW_LAST) begin
                        scroll_pos <= '0;
                    end else begin
                        scroll_pos <= scroll_pos + CNT_W'(1);
                    end
                end
                MODE_BLINK: begin
                    blink_on <= ~blink_on;
                end
                MODE_REVEAL: begin
                    if (reveal_cnt < TW_CNT) begin
                        reveal_cnt <= reveal_cnt + CNT_W'(1);
                    end else begin
                        reveal_cnt <= reveal_cnt;
                    end
                    if (reveal_cnt >= TW_LAST) begin
                        reveal_done <= 1'b1;
                    end else begin
                        reveal_done <= reveal_done;
                    end
                end
                default: begin
                    scroll_pos <= scroll_pos;
                end
            endcase
        end else begin
            mode_q <= mode_q;
        end
    end

endmodule

// File: tb/tb_text_overlay_anim.sv
// Bench for text_overlay_anim: 8x2 bitmap (row0=0x0F, row1=0xA5), 8-pixel cells,
// origin (2,1), two frames per animation step.
module tb_text_overlay_anim;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] x;
    logic [9:0] y;
    logic       frame_start;
    logic       enable;
    logic [1:0] mode;
    logic       overlay_active;
    logic       reveal_done;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic exp;
        int   seq;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic [9:0] vx;
        logic [9:0] vy;
        logic       exp;
    } vec_t;
    vec_t static_vecs[9];

    text_overlay_anim #(
        .TEXT_W      (8),
        .TEXT_H      (2),
        .BITMAP      (16'hA50F),
        .SCALE_LOG2  (3),
        .ORIGIN_X    (2),
        .ORIGIN_Y    (1),
        .STEP_FRAMES (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .x              (x),
        .y              (y),
        .frame_start    (frame_start),
        .enable         (enable),
        .mode           (mode),
        .overlay_active (overlay_active),
        .reveal_done    (reveal_done)
    );

    always #5 clk = ~clk;

    task automatic check_bit(input string name, input logic act, input logic exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    // Present a pixel, queue its expected flag, compare one cycle later.
    task automatic chk_px(input logic [9:0] vx, input logic [9:0] vy, input logic exp,
                          input string name);
        sb_t e;
        @(negedge clk);
        x = vx;
        y = vy;
        e.exp = exp;
        e.seq = total_cnt;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check_bit($sformatf("%s(#%0d)", name, e.seq), overlay_active, e.exp);
    endtask

    task automatic pulse(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            frame_start = 1'b1;
            @(negedge clk);
            frame_start = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        static_vecs[0] = '{10'd16, 10'd8,  1'b1};  // row0 col0
        static_vecs[1] = '{10'd48, 10'd8,  1'b0};  // row0 col4
        static_vecs[2] = '{10'd8,  10'd8,  1'b0};  // column underflow
        static_vecs[3] = '{10'd80, 10'd8,  1'b0};  // col8, right of bitmap
        static_vecs[4] = '{10'd24, 10'd16, 1'b0};  // row1 col1
        static_vecs[5] = '{10'd16, 10'd16, 1'b1};  // row1 col0
        static_vecs[6] = '{10'd40, 10'd8,  1'b1};  // row0 col3
        static_vecs[7] = '{10'd16, 10'd0,  1'b0};  // row underflow
        static_vecs[8] = '{10'd16, 10'd24, 1'b0};  // row2, below bitmap

        rst = 1'b1;
        x = 10'd16;
        y = 10'd8;
        frame_start = 1'b0;
        enable = 1'b1;
        mode = 2'd0;
        repeat (3) @(negedge clk);
        check_bit("reset_overlay", overlay_active, 1'b0);
        check_bit("reset_done", reveal_done, 1'b0);
        rst = 1'b0;

        // Static mode
        for (int i = 0; i < 9; i++) begin
            chk_px(static_vecs[i].vx, static_vecs[i].vy, static_vecs[i].exp,
                   $sformatf("static_%0d", i));
        end

        // Scroll mode
        mode = 2'd1;
        pulse(1);
        chk_px(10'd40, 10'd8, 1'b1, "scroll0_col3");
        chk_px(10'd72, 10'd8, 1'b0, "scroll0_col7");
        pulse(2);
        chk_px(10'd40, 10'd8, 1'b0, "scroll1_col3");
        chk_px(10'd72, 10'd8, 1'b1, "scroll1_col7");
        pulse(14);
        chk_px(10'd40, 10'd8, 1'b1, "scroll_wrap_col3");

        // Blink mode: on for two frames, off for two
        mode = 2'd2;
        pulse(1);
        for (int f = 0; f < 6; f++) begin
            chk_px(10'd16, 10'd8, ((f / 2) % 2) == 0, $sformatf("blink_f%0d", f));
            pulse(1);
        end

        // Reveal mode
        mode = 2'd3;
        pulse(1);
        check_bit("reveal_done_start", reveal_done, 1'b0);
        pulse(2);
        chk_px(10'd16, 10'd8, 1'b1, "reveal1_col0");
        chk_px(10'd24, 10'd8, 1'b0, "reveal1_col1");
        pulse(2);
        chk_px(10'd24, 10'd8, 1'b1, "reveal2_col1");
        chk_px(10'd32, 10'd8, 1'b0, "reveal2_col2");
        pulse(11);
        check_bit("reveal_done_f15", reveal_done, 1'b0);
        pulse(1);
        check_bit("reveal_done_f16", reveal_done, 1'b1);
        chk_px(10'd72, 10'd16, 1'b1, "reveal_full_row1_col7");
        pulse(4);
        check_bit("reveal_done_f20", reveal_done, 1'b1);

        // Mode 3 -> 1: nothing changes until the frame boundary
        mode = 2'd1;
        repeat (3) @(negedge clk);
        check_bit("done_hold_before_latch", reveal_done, 1'b1);
        pulse(1);
        check_bit("done_clear_on_switch", reveal_done, 1'b0);
        pulse(10);
        chk_px(10'd40, 10'd8, 1'b1, "scroll5_col3");
        chk_px(10'd16, 10'd8, 1'b0, "scroll5_col0");

        // Enable low: output off, animation frozen
        enable = 1'b0;
        chk_px(10'd40, 10'd8, 1'b0, "disabled_col3");
        pulse(3);
        enable = 1'b1;
        chk_px(10'd40, 10'd8, 1'b1, "frozen_col3");
        chk_px(10'd16, 10'd8, 1'b0, "frozen_col0");

        // Mode 1 -> 3 with scroll_pos=5
        mode = 2'd3;
        repeat (4) @(negedge clk);
        chk_px(10'd40, 10'd8, 1'b1, "prelatch_col3");
        chk_px(10'd16, 10'd8, 1'b0, "prelatch_col0");
        pulse(1);
        chk_px(10'd16, 10'd8, 1'b0, "reveal_restart_col0");
        check_bit("reveal_restart_done", reveal_done, 1'b0);
        pulse(2);
        chk_px(10'd16, 10'd8, 1'b1, "reveal_restart_step1");

        // Asynchronous reset mid-line
        mode = 2'd1;
        pulse(11);
        chk_px(10'd40, 10'd8, 1'b1, "pre_reset_on");
        #2;
        rst = 1'b1;
        #1;
        check_bit("async_reset_overlay", overlay_active, 1'b0);
        check_bit("async_reset_scroll", (dut.scroll_pos == 8'd0), 1'b1);
        @(negedge clk);
        rst = 1'b0;
        mode = 2'd0;
        chk_px(10'd24, 10'd8, 1'b1, "post_reset_static_col1");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/text_overlay_anim.md
Name: text_overlay_anim

Overview:
- Parametrised successor to the fixed-bitmap VGA text overlay.
- Renders a TEXT_W x TEXT_H 1-bpp bitmap at a cell-aligned origin, with power-of-two pixel scaling.
- Adds frame-driven animation modes: static, horizontal wrap-scroll, blink, left-to-right reveal.
- Sits beside the VGA timing generator; overlay_active feeds the colour mux.

Parameters:
- TEXT_W, 46: bitmap width in cells (1..127).
- TEXT_H, 9: bitmap height in cells (1..63).
- BITMAP, 0: flattened bitmap of TEXT_W*TEXT_H bits. Row r occupies bits [r*TEXT_W +: TEXT_W]; bit 0 of each row is the leftmost cell.
- SCALE_LOG2, 3: cell size is 2^SCALE_LOG2 pixels, both axes.
- ORIGIN_X, 18: left edge, in cells.
- ORIGIN_Y, 12: top edge, in cells.
- STEP_FRAMES, 4: frame_start pulses per animation step (>=1).

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-high reset
- x  in  10  current pixel column
- y  in  10  current pixel row
- frame_start  in  1  one-cycle pulse, once per frame, during blanking
- enable  in  1  overlay enable
- mode  in  2  animation mode: 0 static, 1 scroll, 2 blink, 3 reveal
- overlay_active  out  1  registered pixel-on flag
- reveal_done  out  1  high once reveal has fully uncovered the bitmap

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset values: overlay_active=0, reveal_done=0, mode_q=0, frame_div=0, scroll_pos=0, blink_on=1, reveal_cnt=0.
- Cell coordinates: col = (x>>SCALE_LOG2) - ORIGIN_X; row = (y>>SCALE_LOG2) - ORIGIN_Y. Both are unsigned and 10 bits wide, so underflow wraps to large values.
- In range means col<TEXT_W and row<TEXT_H. Out of range forces overlay_active to 0; the output never holds a stale value.
- Latency: overlay_active is registered, reflecting x,y one cycle after they are presented.
- Source column (scol):
  - mode_q=1: (col+scroll_pos) mod TEXT_W, implemented with a compare-subtract, no divider.
  - All other modes: col.
- Pixel = BITMAP[row*TEXT_W+scol] AND enable AND in_range AND gate, where gate is:
  - mode_q 0 or 1: 1
  - mode_q 2: blink_on
  - mode_q 3: col<reveal_cnt
- Frame ticker:
  - On frame_start with enable=1, frame_div increments.
  - At STEP_FRAMES-1 it wraps to 0 and raises step for that cycle.
  - With enable=0, all animation state freezes.
- State update on step, by mode_q:
  - 1: scroll_pos increments, wrapping TEXT_W-1 to 0.
  - 2: blink_on toggles.
  - 3: reveal_cnt increments, saturating at TEXT_W. reveal_done is set when reveal_cnt reaches TEXT_W and holds.
  - 0: no change.
- Mode latch:
  - mode is sampled into mode_q only on frame_start, so a change never tears a frame.
  - If the sampled value differs from mode_q: frame_div, scroll_pos and reveal_cnt clear to 0, blink_on sets to 1, reveal_done clears, and step is suppressed that cycle.
  - Re-selecting the same mode has no effect.
- Reset mid-frame: all state clears immediately; overlay_active is 0 until the first clock after rst deasserts.

Decomposition:
- Package text_overlay_pkg:
  - MODE_STATIC=2'd0, MODE_SCROLL=2'd1, MODE_BLINK=2'd2, MODE_REVEAL=2'd3
  - coordinate width constant COORD_W=10
- Sub-module overlay_frame_ticker (clk, rst, frame_start, enable, clear → step): holds the frame_div counter.
- Everything else lives in the top.

Test Plan:
Bench config: TEXT_W=8, TEXT_H=2, BITMAP=16'hA50F (row0=0x0F, row1=0xA5), SCALE_LOG2=3, ORIGIN_X=2, ORIGIN_Y=1, STEP_FRAMES=2, enable=1.
- Static, y=8 (row0):
  - x=16 (col0) → overlay_active=1 one cycle later.
  - x=48 (col4) → 0.
  - x=8 (underflow) → 0.
  - x=80 (col8) → 0.
  - y=16, x=24 (row1, col1) → 0; x=16 (col0) → 1.
- Scroll, y=8, x=40 (col3):
  - Frame 0 → 1.
  - After 2 frame_starts scroll_pos=1, so scol=4 → 0.
  - After 16 frame_starts scroll_pos wraps to 0 → 1 again.
  - col7 at scroll_pos=1 gives scol=0 → 1.
- Blink, x=16, y=8: frames 0-1 → 1; frames 2-3 → 0; frames 4-5 → 1.
- Reveal, y=8:
  - After 2 frames x=16 → 1 and x=24 → 0; after 4 frames x=24 → 1.
  - reveal_done rises after 16 frames and stays high through frame 20.
- Mode switch and enable:
  - Change mode 1→3 with scroll_pos=5; at next frame_start reveal_cnt=0 and reveal_done=0. No state change before that frame_start.
  - enable=0 → overlay_active=0 next cycle and counters frozen across 3 frame_starts.
- Async reset: assert rst mid-line with scroll_pos=5 and overlay_active=1 → overlay_active=0 and scroll_pos=0 immediately, without waiting for a clock edge.
